// File: rtl/srl_cascade_chain.sv
// srl_cascade_chain: a chain of addressable shift-register stages, one per LUT.
// Each stage shifts in either its own external bit or the last tap of the
// previous stage. Each stage also tracks how far it has been filled. The read
// port is either combinational or registered.
module srl_cascade_chain #(
    parameter int               STAGES  = 4,
    parameter int               DEPTH   = 32,
    parameter int               ADDR_W  = $clog2(DEPTH),
    parameter int               OUT_REG = 1,
    parameter logic [DEPTH-1:0] INIT    = {DEPTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STAGES-1:0]        ce,
    input  logic [STAGES-1:0]        d,
    input  logic [STAGES-1:0]        casc_sel,
    input  logic [STAGES*ADDR_W-1:0] addr,
    output logic [STAGES-1:0]        q,
    output logic [STAGES-1:0]        q_last,
    output logic [STAGES-1:0]        q_vld,
    output logic [STAGES-1:0]        full
);

    // Saturation point of the fill counter. It is sized to the counter so the
    // compare keeps matching widths.
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);

    logic [STAGES-1:0] w_last;   // tap DEPTH-1 of every stage
    logic [STAGES-1:0] w_rd;     // addressed tap of every stage
    logic [STAGES-1:0] w_rd_vld; // addressed tap holds a shifted-in bit
    logic [STAGES-1:0] w_full;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [DEPTH-1:0]  r_sr;   // tap 0 is the newest bit
        logic [ADDR_W:0]   r_cnt;
        logic              w_in;
        logic [ADDR_W-1:0] w_addr;

        // Stage 0 has no upstream neighbour, so it always takes its external bit.
        if (gi == 0) begin : g_head
            assign w_in = d[0];
        end else begin : g_casc
            assign w_in = casc_sel[gi] ? w_last[gi-1] : d[gi];
        end

        assign w_addr       = addr[gi*ADDR_W +: ADDR_W];
        assign w_last[gi]   = r_sr[DEPTH-1];
        assign w_rd[gi]     = r_sr[w_addr];
        assign w_rd_vld[gi] = (r_cnt > {1'b0, w_addr});
        assign w_full[gi]   = (r_cnt == CNT_MAX);

        // Shift the stage and advance its saturating fill counter on each enabled edge.
        // NOTE: the storage is reset like any other flop (not left as an unreset
        // RAM), because INIT must appear on q_last as soon as rst is asserted.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                // NOTE: use non-blocking assignments so every stage samples its
                // neighbour's pre-edge last tap; a blocking write would ripple the
                // bit through the whole chain in one edge.
                r_sr  <= INIT;
                r_cnt <= '0;
            end else if (ce[gi]) begin
                r_sr <= {r_sr[DEPTH-2:0], w_in};
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign q_last = w_last;
    assign full   = w_full;

    if (OUT_REG != 0) begin : g_out_reg
        logic [STAGES-1:0] r_q;
        logic [STAGES-1:0] r_q_vld;

        // Register the read. It uses the pre-edge storage and the address present at the edge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q     <= '0;
                r_q_vld <= '0;
            end else begin
                r_q     <= w_rd;
                r_q_vld <= w_rd_vld;
            end
        end

        assign q     = r_q;
        assign q_vld = r_q_vld;
    end else begin : g_out_comb
        assign q     = w_rd;
        assign q_vld = w_rd_vld;
    end

endmodule

// File: tb/tb_srl_cascade_chain.sv
// tb_srl_cascade_chain: directed checks of the SRL cascade chain.
// Three instances share the same stimulus:
//   u_reg  - OUT_REG=1, INIT=0
//   u_init - OUT_REG=1, INIT=32'h8000_0001
//   u_comb - OUT_REG=0, INIT=0
module tb_srl_cascade_chain;

    localparam int STAGES = 4;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic                     clk;
    logic                     rst;
    logic [STAGES-1:0]        ce;
    logic [STAGES-1:0]        d;
    logic [STAGES-1:0]        casc_sel;
    logic [STAGES*ADDR_W-1:0] addr;

    logic [STAGES-1:0] q_a, last_a, vld_a, full_a;
    logic [STAGES-1:0] q_b, last_b, vld_b, full_b;
    logic [STAGES-1:0] q_c, last_c, vld_c, full_c;

    int total = 0;
    int bad   = 0;

    srl_cascade_chain #(.STAGES(STAGES), .DEPTH(DEPTH), .OUT_REG(1), .INIT(32'h0)) u_reg (
        .clk(clk), .rst(rst), .ce(ce), .d(d), .casc_sel(casc_sel), .addr(addr),
        .q(q_a), .q_last(last_a), .q_vld(vld_a), .full(full_a));

    srl_cascade_chain #(.STAGES(STAGES), .DEPTH(DEPTH), .OUT_REG(1), .INIT(32'h8000_0001)) u_init (
        .clk(clk), .rst(rst), .ce(ce), .d(d), .casc_sel(casc_sel), .addr(addr),
        .q(q_b), .q_last(last_b), .q_vld(vld_b), .full(full_b));

    srl_cascade_chain #(.STAGES(STAGES), .DEPTH(DEPTH), .OUT_REG(0), .INIT(32'h0)) u_comb (
        .clk(clk), .rst(rst), .ce(ce), .d(d), .casc_sel(casc_sel), .addr(addr),
        .q(q_c), .q_last(last_c), .q_vld(vld_c), .full(full_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [STAGES-1:0]        ce;
        logic [STAGES-1:0]        d;
        logic [STAGES-1:0]        casc;
        logic [STAGES*ADDR_W-1:0] addr;
        logic [STAGES-1:0]        exp_q;
        logic [STAGES-1:0]        exp_vld;
        logic [STAGES-1:0]        exp_full;
        logic [STAGES-1:0]        exp_last;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse, applied between clock edges.
    task automatic do_reset();
        rst      = 1'b1;
        ce       = '0;
        d        = '0;
        casc_sel = '0;
        addr     = '0;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        ce       = '0;
        d        = '0;
        casc_sel = '0;
        addr     = '0;
        step();

        // Reset state.
        check("rst_q",    32'(q_a),    32'h0);
        check("rst_vld",  32'(vld_a),  32'h0);
        check("rst_full", 32'(full_a), 32'h0);
        check("rst_last", 32'(last_a), 32'h0);
        check("rst_last_init", 32'(last_b), 32'hF);
        rst = 1'b0;

        // Test 1: table-driven single-stage fill and addressed read.
        //            ce       d        casc     addr    q        vld      full     last
        vecs[0] = '{4'b0001, 4'b0001, 4'b0000, 20'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[1] = '{4'b0001, 4'b0000, 4'b0000, 20'd0, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        vecs[2] = '{4'b0001, 4'b0000, 4'b0000, 20'd0, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        vecs[3] = '{4'b0001, 4'b0000, 4'b0000, 20'd0, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        vecs[4] = '{4'b0001, 4'b0000, 4'b0000, 20'd0, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        vecs[5] = '{4'b0000, 4'b0000, 4'b0000, 20'd4, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        vecs[6] = '{4'b0000, 4'b0000, 4'b0000, 20'd5, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[7] = '{4'b0000, 4'b0000, 4'b0000, 20'd4, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            ce       = vecs[i].ce;
            d        = vecs[i].d;
            casc_sel = vecs[i].casc;
            addr     = vecs[i].addr;
            step();
            check($sformatf("t1_q[%0d]", i),    32'(q_a),    32'(vecs[i].exp_q));
            check($sformatf("t1_vld[%0d]", i),  32'(vld_a),  32'(vecs[i].exp_vld));
            check($sformatf("t1_full[%0d]", i), 32'(full_a), 32'(vecs[i].exp_full));
            check($sformatf("t1_last[%0d]", i), 32'(last_a), 32'(vecs[i].exp_last));
        end

        // Test 2: full cascade behaves as one 128-bit shift register.
        do_reset();
        casc_sel = 4'b1110;
        ce       = 4'b1111;
        d        = 4'b0001;
        for (int e = 1; e <= 130; e++) begin
            logic [3:0] exp_last;
            step();
            d = 4'b0000;
            exp_last = 4'b0000;
            if (e == 32)  exp_last = 4'b0001;
            if (e == 64)  exp_last = 4'b0010;
            if (e == 96)  exp_last = 4'b0100;
            if (e == 128) exp_last = 4'b1000;
            check($sformatf("t2_last_e%0d", e), 32'(last_a), 32'(exp_last));
        end

        // Test 3: stage 2 saturates; full rises after edge 32 and stays set.
        do_reset();
        ce   = 4'b0100;
        d    = 4'b0100;
        addr = 20'(31) << (2 * ADDR_W);
        for (int e = 1; e <= 40; e++) begin
            step();
            check($sformatf("t3_full_e%0d", e), 32'(full_a[2]), (e >= 32) ? 32'h1 : 32'h0);
            check($sformatf("t3_vld_e%0d", e),  32'(vld_a[2]),  (e >= 33) ? 32'h1 : 32'h0);
            check($sformatf("t3_q_e%0d", e),    32'(q_a[2]),    (e >= 33) ? 32'h1 : 32'h0);
        end
        ce = 4'b0000;
        step();
        check("t3_full_hold", 32'(full_a), 32'b0100);
        check("t3_vld_hold",  32'(vld_a),  32'b0100);

        // Test 4: shift stage 0 with ce[1]=0; the bit leaving stage 0 is dropped.
        do_reset();
        ce = 4'b0001;
        d  = 4'b0001;
        for (int e = 0; e < DEPTH; e++) step();
        check("t4_preload_last", 32'(last_a), 32'b0001);
        casc_sel = 4'b0010;
        d        = 4'b0000;
        step();
        ce = 4'b0000;
        check("t4_last",  32'(last_a), 32'b0001);
        check("t4_full",  32'(full_a), 32'b0001);
        step();
        check("t4_q",     32'(q_a),    32'b0000);
        check("t4_vld",   32'(vld_a),  32'b0001);
        check("t4_comb_last", 32'(last_c), 32'b0001);

        // Test 5: asynchronous reset between edges with INIT=32'h8000_0001.
        #2;
        rst = 1'b1;
        #1;
        check("t5_q_async",    32'(q_b),    32'h0);
        check("t5_vld_async",  32'(vld_b),  32'h0);
        check("t5_full_async", 32'(full_b), 32'h0);
        check("t5_last_async", 32'(last_b), 32'hF);
        check("t5_full_a_async", 32'(full_a), 32'h0);
        #1;
        rst  = 1'b0;
        addr = '0;
        ce   = '0;
        step();
        check("t5_q_after",   32'(q_b),   32'hF);
        check("t5_vld_after", 32'(vld_b), 32'h0);
        check("t5_last_hold", 32'(last_b), 32'hF);

        // Test 6: combinational read follows addr with no clock.
        do_reset();
        ce = 4'b0001;
        d  = 4'b0001;
        step();
        d = 4'b0000;
        step();
        ce   = 4'b0000;
        addr = 20'd0;
        #1;
        check("t6_q_a0",   32'(q_c[0]),   32'h0);
        check("t6_vld_a0", 32'(vld_c[0]), 32'h1);
        addr = 20'd1;
        #1;
        check("t6_q_a1",   32'(q_c[0]),   32'h1);
        check("t6_vld_a1", 32'(vld_c[0]), 32'h1);
        addr = 20'd2;
        #1;
        check("t6_vld_a2", 32'(vld_c[0]), 32'h0);
        addr = 20'd0;
        #1;
        check("t6_q_back", 32'(q_c[0]),   32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
